// File: rtl/alu_pkg.sv
// alu_pkg: funct codes, sequencer state encoding and funct-valid check
// shared by the ALU sharing controller and its ALU.
`default_nettype none

package alu_pkg;

  localparam logic [5:0] FN_ADD = 6'd27;
  localparam logic [5:0] FN_SUB = 6'd28;
  localparam logic [5:0] FN_SRL = 6'd29;
  localparam logic [5:0] FN_SLL = 6'd30;
  localparam logic [5:0] FN_XOR = 6'd31;
  localparam logic [5:0] FN_AND = 6'd32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  function automatic logic funct_valid(input logic [5:0] funct);
    return (funct >= FN_ADD) && (funct <= FN_AND);
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_share_ctrl_alu.sv
// ALU: purely combinational 32-bit ALU; carry is meaningful for ADD only.
`default_nettype none

module ALU
  import alu_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [5:0]  funct_i,
  input  logic [4:0]  shamt_i,
  output logic [31:0] result_o,
  output logic        carry_o
);

  logic [32:0] sum;

  always_comb begin
    sum      = {1'b0, a_i} + {1'b0, b_i};
    result_o = 32'd0;
    carry_o  = 1'b0;
    case (funct_i)
      FN_ADD: begin
        result_o = sum[31:0];
        carry_o  = sum[32];
      end
      FN_SUB:  result_o = a_i - b_i;
      FN_SRL:  result_o = a_i >> shamt_i;
      FN_SLL:  result_o = a_i << shamt_i;
      FN_XOR:  result_o = a_i ^ b_i;
      FN_AND:  result_o = a_i & b_i;
      default: result_o = 32'd0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: arbitrates two requesters onto one ALU and returns a
// registered, ID-tagged response over valid/ready.
`default_nettype none

module alu_share_ctrl
  import alu_pkg::*;
#(
  parameter int PRIO_MODE = 0,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [31:0]      req0_src1,
  input  logic [31:0]      req0_src2,
  input  logic [5:0]       req0_funct,
  input  logic [4:0]       req0_shamt,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [31:0]      req1_src1,
  input  logic [31:0]      req1_src2,
  input  logic [5:0]       req1_funct,
  input  logic [4:0]       req1_shamt,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [31:0]      rsp_result,
  output logic             rsp_zero,
  output logic             rsp_carry,
  output logic             rsp_err,
  output logic             busy,
  output logic [CNT_W-1:0] ops_done
);

  state_e            state_q, state_d;
  logic              last_grant_q;
  logic [31:0]       op_src1_q, op_src2_q;
  logic [5:0]        op_funct_q;
  logic [4:0]        op_shamt_q;
  logic              op_id_q;
  logic              rsp_id_q, rsp_zero_q, rsp_carry_q, rsp_err_q;
  logic [31:0]       rsp_result_q;
  logic [CNT_W-1:0]  ops_done_q;

  logic              grant_id;
  logic              accept;
  logic [31:0]       alu_result;
  logic              alu_carry;

  ALU u_alu (
    .a_i      (op_src1_q),
    .b_i      (op_src2_q),
    .funct_i  (op_funct_q),
    .shamt_i  (op_shamt_q),
    .result_o (alu_result),
    .carry_o  (alu_carry)
  );

  // Contention goes to the port that did not win last time, unless fixed priority.
  always_comb begin
    grant_id = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_id = (PRIO_MODE != 0) ? 1'b0 : ~last_grant_q;
    end else begin
      grant_id = ~req0_valid;
    end
  end

  assign req0_ready = (state_q == IDLE) && req0_valid && !grant_id;
  assign req1_ready = (state_q == IDLE) && req1_valid && grant_id;
  assign accept     = req0_ready || req1_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      op_src1_q    <= 32'd0;
      op_src2_q    <= 32'd0;
      op_funct_q   <= 6'd0;
      op_shamt_q   <= 5'd0;
      op_id_q      <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= 32'd0;
      rsp_zero_q   <= 1'b0;
      rsp_carry_q  <= 1'b0;
      rsp_err_q    <= 1'b0;
      ops_done_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_src1_q    <= grant_id ? req1_src1  : req0_src1;
        op_src2_q    <= grant_id ? req1_src2  : req0_src2;
        op_funct_q   <= grant_id ? req1_funct : req0_funct;
        op_shamt_q   <= grant_id ? req1_shamt : req0_shamt;
        op_id_q      <= grant_id;
        last_grant_q <= grant_id;
      end
      if (state_q == EXEC) begin
        rsp_id_q <= op_id_q;
        if (funct_valid(op_funct_q)) begin
          rsp_result_q <= alu_result;
          rsp_zero_q   <= (alu_result == 32'd0);
          rsp_carry_q  <= alu_carry;
          rsp_err_q    <= 1'b0;
        end else begin
          rsp_result_q <= 32'd0;
          rsp_zero_q   <= 1'b0;
          rsp_carry_q  <= 1'b0;
          rsp_err_q    <= 1'b1;
        end
      end
      if ((state_q == RESP) && rsp_ready) begin
        ops_done_q <= ops_done_q + 1'b1;
      end
    end
  end

  assign rsp_valid  = (state_q == RESP);
  assign busy       = (state_q != IDLE);
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_zero   = rsp_zero_q;
  assign rsp_carry  = rsp_carry_q;
  assign rsp_err    = rsp_err_q;
  assign ops_done   = ops_done_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_share_ctrl.sv
// tb_alu_share_ctrl: directed vectors for the shared-ALU sequencer; a
// round-robin/16-bit-counter instance and a fixed-priority/2-bit-counter instance.
`default_nettype none

module tb_alu_share_ctrl;

  typedef struct {
    logic        port;
    logic [31:0] s1;
    logic [31:0] s2;
    logic [5:0]  fn;
    logic [4:0]  sh;
    logic [31:0] res;
    logic        z;
    logic        c;
    logic        e;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic [31:0] req0_src1 = '0, req0_src2 = '0, req1_src1 = '0, req1_src2 = '0;
  logic [5:0]  req0_funct = '0, req1_funct = '0;
  logic [4:0]  req0_shamt = '0, req1_shamt = '0;
  logic        rsp_ready = 1'b0;

  logic        req0_ready, req1_ready, rsp_valid, rsp_id, rsp_zero, rsp_carry, rsp_err, busy;
  logic [31:0] rsp_result;
  logic [15:0] ops_done;
  logic        req0_ready_b, req1_ready_b, rsp_valid_b, rsp_id_b, rsp_zero_b, rsp_carry_b, rsp_err_b, busy_b;
  logic [31:0] rsp_result_b;
  logic [1:0]  ops_done_b;

  int n_pass = 0;
  int n_total = 0;
  int exp_ops = 0;
  vec_t vecs[10];

  always #5 clk = ~clk;

  alu_share_ctrl #(.PRIO_MODE(0), .CNT_W(16)) dut_rr (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_src1(req0_src1), .req0_src2(req0_src2),
    .req0_funct(req0_funct), .req0_shamt(req0_shamt),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_src1(req1_src1), .req1_src2(req1_src2),
    .req1_funct(req1_funct), .req1_shamt(req1_shamt),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
    .rsp_zero(rsp_zero), .rsp_carry(rsp_carry), .rsp_err(rsp_err), .busy(busy), .ops_done(ops_done)
  );

  alu_share_ctrl #(.PRIO_MODE(1), .CNT_W(2)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready_b), .req0_src1(req0_src1), .req0_src2(req0_src2),
    .req0_funct(req0_funct), .req0_shamt(req0_shamt),
    .req1_valid(req1_valid), .req1_ready(req1_ready_b), .req1_src1(req1_src1), .req1_src2(req1_src2),
    .req1_funct(req1_funct), .req1_shamt(req1_shamt),
    .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready), .rsp_id(rsp_id_b), .rsp_result(rsp_result_b),
    .rsp_zero(rsp_zero_b), .rsp_carry(rsp_carry_b), .rsp_err(rsp_err_b), .busy(busy_b), .ops_done(ops_done_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  task automatic do_reset();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready  = 1'b0;
    rst_n      = 1'b0;
    repeat (2) @(negedge clk);
    rst_n   = 1'b1;
    exp_ops = 0;
  endtask

  // One op end to end: accept, EXEC, RESP with checks, then handshake.
  task automatic do_op(input vec_t v);
    @(negedge clk);
    if (v.port) begin
      req1_valid = 1'b1; req1_src1 = v.s1; req1_src2 = v.s2; req1_funct = v.fn; req1_shamt = v.sh;
    end else begin
      req0_valid = 1'b1; req0_src1 = v.s1; req0_src2 = v.s2; req0_funct = v.fn; req0_shamt = v.sh;
    end
    #1;
    chk("grant_ready", v.port ? req1_ready : req0_ready, 1);
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    chk("exec_busy", busy, 1);
    chk("exec_no_rsp", rsp_valid, 0);
    @(negedge clk);
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_id", rsp_id, v.port);
    chk("rsp_result", rsp_result, v.res);
    chk("rsp_zero", rsp_zero, v.z);
    chk("rsp_carry", rsp_carry, v.c);
    chk("rsp_err", rsp_err, v.e);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    exp_ops++;
    chk("idle_busy", busy, 0);
    chk("ops_done", ops_done, exp_ops);
    chk("ops_done_w2", ops_done_b, exp_ops % 4);
  endtask

  initial begin
    int g_rr[8];
    int c_rr[8];
    int g_fp[8];
    int c_fp[8];
    int n_rr;
    int n_fp;

    vecs[0] = '{1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 6'd27, 5'd0,  32'h0000_0000, 1'b1, 1'b1, 1'b0};
    vecs[1] = '{1'b1, 32'd5,         32'd7,         6'd28, 5'd0,  32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 32'h0000_0001, 32'h0,         6'd30, 5'd31, 32'h8000_0000, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 32'h8000_0000, 32'h0,         6'd29, 5'd31, 32'h0000_0001, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 32'd3,         32'd4,         6'd0,  5'd0,  32'h0000_0000, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{1'b0, 32'hA5A5_A5A5, 32'hFFFF_0000, 6'd31, 5'd0,  32'h5A5A_A5A5, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 6'd32, 5'd0,  32'h00F0_00F0, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{1'b0, 32'd1,         32'd2,         6'd27, 5'd0,  32'h0000_0003, 1'b0, 1'b0, 1'b0};
    vecs[8] = '{1'b1, 32'd9,         32'd9,         6'd33, 5'd0,  32'h0000_0000, 1'b0, 1'b0, 1'b1};
    vecs[9] = '{1'b1, 32'd7,         32'd7,         6'd28, 5'd0,  32'h0000_0000, 1'b1, 1'b0, 1'b0};

    // Reset values while held in reset.
    #1;
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ops_done", ops_done, 0);
    chk("rst_result", rsp_result, 0);
    chk("rst_ready", {req0_ready, req1_ready}, 0);
    do_reset();

    foreach (vecs[i]) do_op(vecs[i]);

    // Contention with rsp_ready held high: round-robin alternates, priority always port 0.
    do_reset();
    @(negedge clk);
    req0_valid = 1'b1; req0_src1 = 32'd1; req0_src2 = 32'd1; req0_funct = 6'd27;
    req1_valid = 1'b1; req1_src1 = 32'd2; req1_src2 = 32'd2; req1_funct = 6'd27;
    rsp_ready  = 1'b1;
    n_rr = 0;
    n_fp = 0;
    for (int c = 0; c < 12; c++) begin
      #1;
      chk("one_grant_rr", req0_ready & req1_ready, 0);
      if ((req0_ready || req1_ready) && n_rr < 8) begin
        g_rr[n_rr] = int'(req1_ready); c_rr[n_rr] = c; n_rr++;
      end
      if ((req0_ready_b || req1_ready_b) && n_fp < 8) begin
        g_fp[n_fp] = int'(req1_ready_b); c_fp[n_fp] = c; n_fp++;
      end
      @(negedge clk);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
    rsp_ready = 1'b0;
    exp_ops = 4;
    chk("rr_grants", n_rr, 4);
    chk("fp_grants", n_fp, 4);
    for (int i = 0; i < 4; i++) begin
      if (i < n_rr) begin
        chk("rr_id", g_rr[i], i % 2);
        chk("rr_cycle", c_rr[i], 3 * i);
      end
      if (i < n_fp) begin
        chk("fp_id", g_fp[i], 0);
        chk("fp_cycle", c_fp[i], 3 * i);
      end
    end
    chk("contend_ops", ops_done, 4);

    // Response back-pressure: outputs hold, no grants, busy stays high.
    @(negedge clk);
    req1_valid = 1'b1; req1_src1 = 32'd10; req1_src2 = 32'd20; req1_funct = 6'd27; req1_shamt = 5'd0;
    @(negedge clk);
    req1_valid = 1'b0;
    @(negedge clk);
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("stall_valid", rsp_valid, 1);
      chk("stall_result", rsp_result, 32'd30);
      chk("stall_id", rsp_id, 1);
      chk("stall_ready", {req0_ready, req1_ready}, 0);
      chk("stall_busy", busy, 1);
      @(negedge clk);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready  = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("stall_release_idle", busy, 0);
    chk("stall_ops", ops_done, 5);

    // Reset asserted mid-EXEC discards the op.
    @(negedge clk);
    req0_valid = 1'b1; req0_src1 = 32'd4; req0_src2 = 32'd4; req0_funct = 6'd27;
    @(negedge clk);
    req0_valid = 1'b0;
    chk("pre_rst_busy", busy, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_rsp_valid", rsp_valid, 0);
    chk("arst_ops_done", ops_done, 0);
    chk("arst_rsp_id", rsp_id, 0);
    chk("arst_result", rsp_result, 0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_ops = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("no_rsp_after_rst", rsp_valid, 0);
    end

    // Five completions wrap the 2-bit counter to 1.
    for (int i = 0; i < 5; i++) do_op(vecs[i]);
    chk("wrap_w2", ops_done_b, 1);
    chk("wrap_w16", ops_done, 5);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
